// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, fetches over req/gnt/rvalid, applies redirects and stalls, drives IF/ID.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int PC_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EX_MEM_PCSrc,
  input  logic [ADDR_W-1:0] EX_MEM_NPC,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       IF_ID_INSTR,
  output logic [ADDR_W-1:0] IF_ID_NPC,
  output logic              IF_ID_VALID
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  state_t state, next_state;
  logic [ADDR_W-1:0] pc, inflight_pc, hold_npc;
  logic [31:0] hold_instr;
  logic hold_full, drop;
  logic granted, take, park, load_wait, load_hold;
  assign granted   = state == S_REQ && imem_gnt;
  assign take      = state == S_WAIT && imem_rvalid && !drop && !EX_MEM_PCSrc;
  assign park      = take && stall;
  assign load_wait = take && !stall;
  assign load_hold = state == S_HOLD && hold_full && !stall && !EX_MEM_PCSrc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      S_BOOT:  next_state = S_REQ;
      S_REQ:   next_state = imem_gnt ? S_WAIT : S_REQ;
      S_WAIT:  next_state = !imem_rvalid ? S_WAIT : park ? S_HOLD : S_REQ;
      S_HOLD:  next_state = (EX_MEM_PCSrc || !stall) ? S_REQ : S_HOLD;
      default: next_state = S_BOOT;
    endcase
  end
  always_comb begin
    imem_req  = state == S_REQ;
    imem_addr = pc;
  end
  // A redirect racing a grant or an outstanding response marks that response stale via drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      drop        <= 1'b0;
      hold_instr  <= NOP;
      hold_npc    <= '0;
      hold_full   <= 1'b0;
      IF_ID_INSTR <= NOP;
      IF_ID_NPC   <= '0;
      IF_ID_VALID <= 1'b0;
    end else begin
      if (EX_MEM_PCSrc) pc <= EX_MEM_NPC;
      else if (granted) pc <= pc + STEP;
      if (granted) inflight_pc <= pc;
      if (state == S_WAIT) drop <= !imem_rvalid && (drop || EX_MEM_PCSrc);
      else if (granted) drop <= EX_MEM_PCSrc;
      if (park) begin
        hold_instr <= imem_rdata;
        hold_npc   <= inflight_pc + STEP;
        hold_full  <= 1'b1;
      end else if (state == S_HOLD && (EX_MEM_PCSrc || !stall)) hold_full <= 1'b0;
      if (EX_MEM_PCSrc) IF_ID_VALID <= 1'b0;
      else if (load_wait) begin
        IF_ID_INSTR <= imem_rdata;
        IF_ID_NPC   <= inflight_pc + STEP;
        IF_ID_VALID <= 1'b1;
      end else if (load_hold) begin
        IF_ID_INSTR <= hold_instr;
        IF_ID_NPC   <= hold_npc;
        IF_ID_VALID <= 1'b1;
      end else if (!stall) IF_ID_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench; stimulus queues expected IF/ID loads, a monitor pops them.
module tb_fetch_ctrl;
  logic clk = 0, rst_n, w_rst_n;
  logic pcsrc, stall, imem_req, imem_gnt, imem_rvalid, valid;
  logic [31:0] npc_in, imem_addr, imem_rdata, instr, npc;
  logic w_req, w_rvalid, w_valid, w_prev_req;
  logic [31:0] w_addr, w_instr, w_npc;
  logic [63:0] q[$];
  int n_chk = 0, n_fail = 0;
  int gnt_dly, rv_dly, credits, req_cnt = 0, rv_cnt = 0;
  logic pend = 0;
  logic [31:0] gaddr = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .EX_MEM_PCSrc(pcsrc), .EX_MEM_NPC(npc_in), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .IF_ID_INSTR(instr), .IF_ID_NPC(npc), .IF_ID_VALID(valid)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .EX_MEM_PCSrc(1'b0), .EX_MEM_NPC(32'h0), .stall(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1), .imem_rvalid(w_rvalid),
    .imem_rdata(32'hCAFE_F00D), .IF_ID_INSTR(w_instr), .IF_ID_NPC(w_npc), .IF_ID_VALID(w_valid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: grants after gnt_dly request cycles while credits last, answers rv_dly cycles later, rdata = addr*16.
  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    forever begin
      @(negedge clk);
      if (imem_rvalid) pend = 0;
      if (imem_gnt) begin pend = 1; rv_cnt = 0; imem_rdata = gaddr << 4; end
      if (pend) rv_cnt++;
      imem_rvalid = pend && rv_cnt >= rv_dly;
      req_cnt = imem_req ? req_cnt + 1 : 0;
      imem_gnt = imem_req && req_cnt > gnt_dly && credits > 0;
      if (imem_gnt) begin gaddr = imem_addr; credits--; end
    end
  end

  initial begin
    w_rvalid = 0; w_prev_req = 0;
    forever begin
      @(negedge clk);
      w_rvalid = w_prev_req && !w_req;
      w_prev_req = w_req;
    end
  end

  // Monitor: a load happened whenever VALID is high after an edge at which stall was low.
  always @(posedge clk) begin
    logic s;
    logic [63:0] e;
    s = stall;
    #1;
    if (rst_n && valid && !s) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_load: got npc %0h instr %0h, none expected", npc, instr);
      end else begin
        e = q.pop_front();
        chk("if_id_npc_instr", {npc, instr}, e);
      end
    end
  end

  task automatic wait_req(input logic lvl);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (imem_req !== lvl && n < 50);
    chk("wait_req", {63'h0, imem_req}, {63'h0, lvl});
  endtask

  task automatic wait_npc(input logic [31:0] v);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (!(valid && npc == v) && n < 50);
    chk("wait_npc", {32'h0, npc}, {32'h0, v});
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin @(posedge clk); #2; n++; end
    chk("drain", 64'(q.size()), 64'h0);
  endtask

  initial begin
    int n;
    rst_n = 0; w_rst_n = 0; stall = 0; pcsrc = 0; npc_in = 0;
    gnt_dly = 0; rv_dly = 1; credits = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_npc", {32'h0, npc}, 64'h0);
    chk("rst_valid", {63'h0, valid}, 64'h0);
    chk("w_rst_addr", {32'h0, w_addr}, 64'hFFFF_FFFF);
    // Free run with single-cycle memory, then stall while the fetch of addr 2 returns.
    q.push_back({32'd1, 32'h00});
    q.push_back({32'd2, 32'h10});
    q.push_back({32'd3, 32'h20});
    @(negedge clk); credits = 3; rst_n = 1; w_rst_n = 1;
    wait_npc(32'd2);
    @(negedge clk); stall = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("stall_hold_npc", {32'h0, npc}, 64'd2);
    chk("stall_hold_valid", {63'h0, valid}, 64'h1);
    chk("hold_no_req", {63'h0, imem_req}, 64'h0);
    @(negedge clk); rv_dly = 2;
    @(posedge clk);
    @(negedge clk); stall = 0;
    drain(20);
    // Redirect to 5 while the fetch of 3 is outstanding.
    q.push_back({32'd6, 32'h50});
    @(negedge clk); credits = 2;
    wait_req(1'b0);
    @(negedge clk); pcsrc = 1; npc_in = 32'h5;
    @(negedge clk); pcsrc = 0;
    @(posedge clk); #2;
    chk("redirect_req", {63'h0, imem_req}, 64'h1);
    chk("redirect_addr", {32'h0, imem_addr}, 64'h5);
    drain(20);
    // Park a response in HOLD, then redirect while still stalled.
    @(negedge clk); stall = 1; credits = 1;
    wait_req(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); pcsrc = 1; npc_in = 32'h40;
    @(negedge clk); pcsrc = 0;
    #1;
    chk("hold_redirect_req", {63'h0, imem_req}, 64'h1);
    chk("hold_redirect_addr", {32'h0, imem_addr}, 64'h40);
    chk("hold_redirect_flush", {63'h0, valid}, 64'h0);
    // Slow memory: address must stay put until granted, one load per response.
    q.push_back({32'h41, 32'h400});
    q.push_back({32'h42, 32'h410});
    q.push_back({32'h43, 32'h420});
    @(negedge clk); gnt_dly = 3; rv_dly = 2; credits = 3; stall = 0;
    begin
      logic pr;
      logic [31:0] pa;
      pr = imem_req; pa = imem_addr; n = 0;
      while (q.size() != 0 && n < 80) begin
        @(posedge clk); #2; n++;
        if (pr && imem_req && !imem_gnt) chk("addr_stable", {32'h0, imem_addr}, {32'h0, pa});
        pr = imem_req; pa = imem_addr;
      end
    end
    drain(5);
    // Reset in WAIT; the stale response lands after release and must be ignored.
    @(negedge clk); credits = 1;
    wait_req(1'b0);
    @(negedge clk); #1 rst_n = 0;
    #1;
    chk("mid_rst_req", {63'h0, imem_req}, 64'h0);
    chk("mid_rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("mid_rst_instr", {32'h0, instr}, 64'h0);
    chk("mid_rst_npc", {32'h0, npc}, 64'h0);
    chk("mid_rst_valid", {63'h0, valid}, 64'h0);
    q.push_back({32'd1, 32'h00});
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk); credits = 1;
    drain(40);
    repeat (4) @(posedge clk);
    chk("final_queue", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // PC wrap: reset PC of all-ones yields NPC 0, then 1.
  initial begin
    int n = 0;
    do begin @(posedge clk); #3; n++; end while (!(w_rst_n && w_valid) && n < 40);
    chk("wrap_npc0", {32'h0, w_npc}, 64'h0);
    chk("wrap_instr", {32'h0, w_instr}, 64'hCAFE_F00D);
    @(posedge clk); #3;
    n = 0;
    do begin @(posedge clk); #3; n++; end while (!w_valid && n < 20);
    chk("wrap_npc1", {32'h0, w_npc}, 64'h1);
  end
endmodule
